fsb_prefetch_buffer: RTL and testbench

- Parametrised successor to the single-entry L2 read-prefetch match logic on the 68030 front-side bus.
- Holds ENTRIES fully associative lines of LINE_WORDS longwords each.
- Read hits are terminated synchronously (CPU_nSTERM). Misses start a line fill from the memory side without terminating the cycle; the mainboard terminates it.
- Sits between the address decode/size decode and the CPU termination and data outputs. Write snooping keeps buffered lines coherent.

---
 rtl/fsb_prefetch_buffer.sv | 183 ++++++++++++++++++
 tb/tb_fsb_prefetch_buffer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fsb_prefetch_buffer.sv
// Fully associative read-prefetch line buffer on the 68030 FSB: hits are terminated with CPU_nSTERM,
// misses start a line fill from memory, and cacheable writes are merged into buffered lines.
module fsb_prefetch_buffer #(
  parameter int ADDR_W     = 26,
  parameter int LINE_WORDS = 4,
  parameter int ENTRIES    = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              CPU_nAS,
  input  logic              RW,
  input  logic              CACHE_SEL,
  input  logic [ADDR_W-1:0] A,
  input  logic [31:0]       WRD,
  input  logic [3:0]        WRM,
  input  logic              CLR,
  output logic [31:0]       RDD,
  output logic              CPU_nSTERM,
  output logic              FILL_REQ,
  output logic [ADDR_W-1:0] FILL_A,
  input  logic              FILL_VALID,
  input  logic [31:0]       FILL_D
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int TAG_W = ADDR_W - OFF_W;
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, TERM, FILL, WAITAS} state_t;

  state_t                                   state_q, state_d;
  logic                                     nas_q, nas_d;
  logic [ADDR_W-1:0]                        a_q, a_d;
  logic [ENTRIES-1:0]                       valid_q, valid_d;
  logic [ENTRIES-1:0][TAG_W-1:0]            tag_q, tag_d;
  logic [ENTRIES-1:0][LINE_WORDS-1:0][31:0] data_q, data_d;
  logic [IDX_W-1:0]                         victim_q, victim_d;
  logic [OFF_W-1:0]                         beat_q, beat_d;
  logic                                     poison_q, poison_d;
  logic [31:0]                              rdd_q, rdd_d;
  logic                                     sterm_q, sterm_d;
  logic                                     fill_req_q, fill_req_d;
  logic [ADDR_W-1:0]                        fill_a_q, fill_a_d;

  logic             start, wr_start, wr_hit, lk_hit;
  logic [IDX_W-1:0] wr_idx, lk_idx;
  logic [TAG_W-1:0] a_tag, l_tag;
  logic [OFF_W-1:0] a_word, l_word;

  assign a_tag    = A[ADDR_W-1:OFF_W];
  assign a_word   = A[OFF_W-1:0];
  assign l_tag    = a_q[ADDR_W-1:OFF_W];
  assign l_word   = a_q[OFF_W-1:0];
  assign start    = nas_q & ~CPU_nAS;
  assign wr_start = start & CACHE_SEL & ~RW;

  // Tag match for the live write address and for the latched read address.
  always_comb begin
    wr_hit = 1'b0;
    wr_idx = '0;
    lk_hit = 1'b0;
    lk_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && tag_q[i] == a_tag) begin
        wr_hit = 1'b1;
        wr_idx = IDX_W'(i);
      end
      if (valid_q[i] && tag_q[i] == l_tag) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    nas_d      = CPU_nAS;
    a_d        = a_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    data_d     = data_q;
    victim_d   = victim_q;
    beat_d     = beat_q;
    poison_d   = poison_q;
    rdd_d      = rdd_q;
    sterm_d    = 1'b1;
    fill_req_d = fill_req_q;
    fill_a_d   = fill_a_q;

    // Write merges are honoured both when idle and while a fill is in flight.
    if (wr_start && wr_hit && (state_q == IDLE || state_q == FILL)) begin
      for (int b = 0; b < 4; b++)
        if (WRM[b]) data_d[wr_idx][a_word][8*b +: 8] = WRD[8*b +: 8];
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (CACHE_SEL && RW) begin
            state_d = LOOKUP;
            a_d     = A;
          end else begin
            state_d = WAITAS;
          end
        end
      end
      LOOKUP: begin
        if (CPU_nAS) begin
          state_d = IDLE;
        end else if (lk_hit) begin
          rdd_d   = data_q[lk_idx][l_word];
          sterm_d = 1'b0;
          state_d = TERM;
        end else begin
          fill_req_d        = 1'b1;
          fill_a_d          = {l_tag, {OFF_W{1'b0}}};
          valid_d[victim_q] = 1'b0;
          beat_d            = '0;
          poison_d          = 1'b0;
          state_d           = FILL;
        end
      end
      TERM: state_d = WAITAS;
      FILL: begin
        if ((wr_start && a_tag == l_tag) || CLR) poison_d = 1'b1;
        if (FILL_VALID) begin
          data_d[victim_q][beat_q] = FILL_D;
          beat_d = beat_q + 1'b1;
          if (beat_q == OFF_W'(LINE_WORDS - 1)) begin
            fill_req_d = 1'b0;
            if (!poison_d) begin
              valid_d[victim_q] = 1'b1;
              tag_d[victim_q]   = l_tag;
            end
            victim_d = (victim_q == IDX_W'(ENTRIES - 1)) ? '0 : victim_q + 1'b1;
            state_d  = CPU_nAS ? IDLE : WAITAS;
          end
        end
      end
      WAITAS: if (CPU_nAS) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (CLR) valid_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= IDLE;
      nas_q      <= 1'b1;
      a_q        <= '0;
      valid_q    <= '0;
      tag_q      <= '0;
      victim_q   <= '0;
      beat_q     <= '0;
      poison_q   <= 1'b0;
      rdd_q      <= '0;
      sterm_q    <= 1'b1;
      fill_req_q <= 1'b0;
      fill_a_q   <= '0;
    end else begin
      state_q    <= state_d;
      nas_q      <= nas_d;
      a_q        <= a_d;
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      victim_q   <= victim_d;
      beat_q     <= beat_d;
      poison_q   <= poison_d;
      rdd_q      <= rdd_d;
      sterm_q    <= sterm_d;
      fill_req_q <= fill_req_d;
      fill_a_q   <= fill_a_d;
    end
  end

  // Line data carries no reset; the valid bits gate every use of it.
  always_ff @(posedge CLK) data_q <= data_d;

  assign RDD        = rdd_q;
  assign CPU_nSTERM = sterm_q;
  assign FILL_REQ   = fill_req_q;
  assign FILL_A     = fill_a_q;
endmodule

// File: tb/tb_fsb_prefetch_buffer.sv
// Directed bench for fsb_prefetch_buffer: fills, hits, write merges, replacement,
// poisoned fills, flush, reset mid-fill and aborted lookups.
module tb_fsb_prefetch_buffer;
  logic        CLK = 1'b0;
  logic        nRST, CPU_nAS, RW, CACHE_SEL, CLR, FILL_VALID;
  logic [25:0] A;
  logic [31:0] WRD, FILL_D;
  logic [3:0]  WRM;
  logic [31:0] RDD;
  logic        CPU_nSTERM, FILL_REQ;
  logic [25:0] FILL_A;

  int n_tests = 0;
  int n_fail  = 0;

  fsb_prefetch_buffer #(.ADDR_W(26), .LINE_WORDS(4), .ENTRIES(4)) dut (
    .CLK(CLK), .nRST(nRST), .CPU_nAS(CPU_nAS), .RW(RW), .CACHE_SEL(CACHE_SEL),
    .A(A), .WRD(WRD), .WRM(WRM), .CLR(CLR), .RDD(RDD), .CPU_nSTERM(CPU_nSTERM),
    .FILL_REQ(FILL_REQ), .FILL_A(FILL_A), .FILL_VALID(FILL_VALID), .FILL_D(FILL_D)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_start(input logic [25:0] a);
    CPU_nAS = 1'b1; RW = 1'b1; CACHE_SEL = 1'b1;
    tick();
    CPU_nAS = 1'b0; A = a;
    tick();
    chk("pre_sterm", 32'(CPU_nSTERM), 32'd1);
  endtask

  task automatic read_hit(input logic [25:0] a, input logic [31:0] exp);
    bus_start(a);
    tick();
    chk("hit_sterm_low", 32'(CPU_nSTERM), 32'd0);
    chk("hit_rdd", RDD, exp);
    chk("hit_no_fill", 32'(FILL_REQ), 32'd0);
    tick();
    chk("hit_sterm_release", 32'(CPU_nSTERM), 32'd1);
    CPU_nAS = 1'b1;
    tick();
  endtask

  task automatic read_miss(input logic [25:0] a);
    bus_start(a);
    tick();
    chk("miss_fill_req", 32'(FILL_REQ), 32'd1);
    chk("miss_fill_a", 32'(FILL_A), 32'(a & ~26'd3));
    chk("miss_no_sterm", 32'(CPU_nSTERM), 32'd1);
  endtask

  task automatic fill_beats(input logic [31:0] base);
    for (int i = 0; i < 4; i++) begin
      FILL_VALID = 1'b1;
      FILL_D = base * 32'(i + 1);
      tick();
      chk("fill_sterm", 32'(CPU_nSTERM), 32'd1);
      chk("fill_req_beat", 32'(FILL_REQ), (i < 3) ? 32'd1 : 32'd0);
    end
    FILL_VALID = 1'b0;
    CPU_nAS = 1'b1;
    tick();
  endtask

  task automatic bus_write(input logic [25:0] a, input logic [31:0] d, input logic [3:0] m);
    CPU_nAS = 1'b1; RW = 1'b1;
    tick();
    CPU_nAS = 1'b0; RW = 1'b0; CACHE_SEL = 1'b1; A = a; WRD = d; WRM = m;
    tick();
    chk("write_no_sterm", 32'(CPU_nSTERM), 32'd1);
    CPU_nAS = 1'b1; RW = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    nRST = 1'b0; CPU_nAS = 1'b1; FILL_VALID = 1'b0; CLR = 1'b0;
    tick();
    nRST = 1'b1;
    tick();
  endtask

  initial begin
    nRST = 1'b0; CPU_nAS = 1'b1; RW = 1'b1; CACHE_SEL = 1'b0; CLR = 1'b0;
    FILL_VALID = 1'b0; A = '0; WRD = '0; FILL_D = '0; WRM = '0;
    tick(); tick();
    chk("rst_rdd", RDD, 32'd0);
    chk("rst_sterm", 32'(CPU_nSTERM), 32'd1);
    chk("rst_fill_req", 32'(FILL_REQ), 32'd0);
    chk("rst_fill_a", 32'(FILL_A), 32'd0);
    nRST = 1'b1;
    tick();

    // First fill, hit on word 2, then a partial write merge into word 1.
    read_miss(26'h000100);
    fill_beats(32'h11111111);
    read_hit(26'h000102, 32'h33333333);
    chk("rdd_holds", RDD, 32'h33333333);
    bus_write(26'h000101, 32'hAABBCCDD, 4'b0011);
    read_hit(26'h000101, 32'h2222CCDD);

    // Round-robin replacement: five lines into four entries.
    do_reset();
    read_miss(26'h0); fill_beats(32'h01000000);
    read_miss(26'h4); fill_beats(32'h02000000);
    read_miss(26'h8); fill_beats(32'h03000000);
    read_miss(26'hC); fill_beats(32'h04000000);
    read_miss(26'h10); fill_beats(32'h05000000);
    read_hit(26'h5, 32'h04000000);
    read_miss(26'h0); fill_beats(32'h06000000);
    read_hit(26'h13, 32'h14000000);

    // Write to the line being filled, landing on beat 2, poisons the fill.
    read_miss(26'h200);
    CPU_nAS = 1'b1;
    FILL_VALID = 1'b1; FILL_D = 32'h0000A001; tick();
    FILL_D = 32'h0000A002; tick();
    CPU_nAS = 1'b0; RW = 1'b0; A = 26'h203; WRD = 32'hFFFFFFFF; WRM = 4'hF;
    FILL_D = 32'h0000A003; tick();
    chk("poison_req_mid", 32'(FILL_REQ), 32'd1);
    FILL_D = 32'h0000A004; tick();
    chk("poison_req_done", 32'(FILL_REQ), 32'd0);
    FILL_VALID = 1'b0; CPU_nAS = 1'b1; RW = 1'b1; tick();
    read_miss(26'h200); fill_beats(32'h00000100);
    read_hit(26'h203, 32'h00000400);

    // Flush drops every valid line.
    CLR = 1'b1; tick(); CLR = 1'b0;
    read_miss(26'h10); fill_beats(32'h00000010);
    read_miss(26'h200); fill_beats(32'h00000020);

    // Reset during the second fill beat abandons the fill.
    read_miss(26'h300);
    FILL_VALID = 1'b1; FILL_D = 32'hDEAD0001; tick();
    FILL_D = 32'hDEAD0002; nRST = 1'b0; tick();
    chk("rstfill_req", 32'(FILL_REQ), 32'd0);
    chk("rstfill_sterm", 32'(CPU_nSTERM), 32'd1);
    nRST = 1'b1; FILL_VALID = 1'b0; CPU_nAS = 1'b1; tick();
    read_miss(26'h300); fill_beats(32'h01010101);
    read_hit(26'h302, 32'h03030303);

    // CPU_nAS rising during LOOKUP aborts: no termination, no fill.
    bus_start(26'h500);
    CPU_nAS = 1'b1; tick();
    chk("abort_miss_sterm", 32'(CPU_nSTERM), 32'd1);
    chk("abort_miss_req", 32'(FILL_REQ), 32'd0);
    tick();
    chk("abort_miss_req2", 32'(FILL_REQ), 32'd0);
    bus_start(26'h301);
    CPU_nAS = 1'b1; tick();
    chk("abort_hit_sterm", 32'(CPU_nSTERM), 32'd1);
    chk("abort_hit_rdd", RDD, 32'h03030303);
    tick();
    read_hit(26'h301, 32'h02020202);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
